// File: rtl/id_issue_arbiter.sv
// Round-robin burst arbiter feeding the single ID/issue pipeline register.
// Define ID_ARB_PERF_EN to add the perf_conflict_o contention counter.
module id_issue_arbiter #(
    parameter int NR_PORTS  = 2,
    parameter int DATA_W    = 64,
    parameter int MAX_BURST = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic [NR_PORTS-1:0]          req_valid_i,
    input  logic [NR_PORTS*DATA_W-1:0]   req_data_i,
    input  logic [NR_PORTS-1:0]          req_ctrl_flow_i,
    output logic [NR_PORTS-1:0]          req_ready_o,
    output logic                         issue_valid_o,
    output logic [DATA_W-1:0]            issue_data_o,
    output logic                         issue_ctrl_flow_o,
    output logic [$clog2(NR_PORTS)-1:0]  issue_port_o,
    input  logic                         issue_ack_i
`ifdef ID_ARB_PERF_EN
    ,
    output logic [31:0]                  perf_conflict_o
`endif
);

    localparam int PW = $clog2(NR_PORTS);

    typedef enum logic {IDLE, OWN} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            valid_q;
    logic [DATA_W-1:0] data_q;
    logic            cf_q;
    logic [PW-1:0]   port_q;

    logic            slot;
    logic            grant_any;
    logic [PW-1:0]   grant_idx;
    int              scan_idx;

    function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
        if (p == PW'(NR_PORTS - 1)) return '0;
        return p + 1'b1;
    endfunction

    always_comb begin
        slot      = (!valid_q || issue_ack_i) && !flush_i;
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (slot) begin
            if (state_q == IDLE) begin
                for (int k = 0; k < NR_PORTS; k++) begin
                    scan_idx = int'(rr_q) + k;
                    if (scan_idx >= NR_PORTS) scan_idx = scan_idx - NR_PORTS;
                    if (!grant_any && req_valid_i[scan_idx]) begin
                        grant_any = 1'b1;
                        grant_idx = PW'(scan_idx);
                    end
                end
            end else if (req_valid_i[owner_q]) begin
                grant_any = 1'b1;
                grant_idx = owner_q;
            end else begin
                // Owner ran dry: give up the burst, arbitrate afresh next cycle.
                state_d = IDLE;
                rr_d    = next_port(owner_q);
            end

            if (grant_any) begin
                if (state_q == IDLE) begin
                    if (req_ctrl_flow_i[grant_idx] || MAX_BURST == 1) begin
                        rr_d = next_port(grant_idx);
                    end else begin
                        state_d = OWN;
                        owner_d = grant_idx;
                        cnt_d   = 8'd1;
                    end
                end else if (req_ctrl_flow_i[grant_idx] || int'(cnt_q) + 1 >= MAX_BURST) begin
                    state_d = IDLE;
                    rr_d    = next_port(grant_idx);
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        end

        req_ready_o = '0;
        if (grant_any && !rst_i) req_ready_o[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cf_q    <= 1'b0;
            port_q  <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (grant_any) begin
            valid_q <= 1'b1;
            data_q  <= req_data_i[int'(grant_idx)*DATA_W +: DATA_W];
            cf_q    <= req_ctrl_flow_i[grant_idx];
            port_q  <= grant_idx;
        end else if (issue_ack_i) begin
            valid_q <= 1'b0;
        end
    end

    assign issue_valid_o     = valid_q;
    assign issue_data_o      = data_q;
    assign issue_ctrl_flow_o = cf_q;
    assign issue_port_o      = port_q;

`ifdef ID_ARB_PERF_EN
    int   nr_valid;
    logic conflict;

    always_comb begin
        nr_valid = 0;
        for (int k = 0; k < NR_PORTS; k++) begin
            if (req_valid_i[k]) nr_valid = nr_valid + 1;
        end
        conflict = slot && (nr_valid >= 2);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_conflict_o <= '0;
        end else if (conflict && perf_conflict_o != 32'hFFFF_FFFF) begin
            perf_conflict_o <= perf_conflict_o + 32'd1;
        end
    end
`endif

endmodule
